// File: rtl/alu_ctrl_seq.sv
// Hardwired control sequencer for a fetch/decode/execute ALU datapath.
// Steps through T0..T6 and raises the datapath strobes for each T-state.
module alu_ctrl_seq #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int MEM_TO = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] ir,
  output logic              busy,
  output logic              done,
  output logic              ill_op,
  output logic              mem_err,
  output logic              PCout,
  output logic              IncPC,
  output logic              PCin,
  output logic              MARin,
  output logic              Read,
  output logic              MDRin,
  output logic              MDRout,
  output logic              IRin,
  output logic              Yin,
  output logic              Zin,
  output logic              Zlowout,
  output logic              ZHighout,
  output logic              LOin,
  output logic              HIin,
  output logic [NREGS-1:0]  Rin,
  output logic [NREGS-1:0]  Rout,
  output logic [4:0]        alu_op
);

  localparam int REG_AW = $clog2(NREGS);
  localparam int CW     = $clog2(MEM_TO + 1);
  localparam int LSB    = DATA_W - 5 - 3 * REG_AW;

  typedef enum logic [2:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6
  } state_t;

  state_t state, state_d;

  logic [CW-1:0]     wcnt, wcnt_d;
  logic [4:0]        op_q;
  logic [REG_AW-1:0] ra_q, rb_q, rc_q;

  logic [4:0]        op_ir;
  logic [REG_AW-1:0] ra_ir, rb_ir, rc_ir;
  logic              unused_ir;

  assign op_ir = ir[DATA_W-1 -: 5];
  assign ra_ir = ir[DATA_W-6 -: REG_AW];
  assign rb_ir = ir[DATA_W-6-REG_AW -: REG_AW];
  assign rc_ir = ir[DATA_W-6-2*REG_AW -: REG_AW];
  assign unused_ir = ^ir[LSB-1:0];

  function automatic logic legal(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101,
      5'b00110, 5'b00111, 5'b01000,
      5'b01001, 5'b01010, 5'b01110,
      5'b01111: legal = 1'b1;
      default:  legal = 1'b0;
    endcase
  endfunction

  function automatic logic [NREGS-1:0] onehot(
    input logic [REG_AW-1:0] idx
  );
    onehot = NREGS'(1) << idx;
  endfunction

  logic long_op;
  assign long_op = (op_q == 5'b01110) ||
                   (op_q == 5'b01111);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      wcnt  <= '0;
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
    end else begin
      state <= state_d;
      wcnt  <= wcnt_d;
      if (state == T3) begin
        op_q <= op_ir;
        ra_q <= ra_ir;
        rb_q <= rb_ir;
        rc_q <= rc_ir;
      end
    end
  end

  always_comb begin
    state_d  = state;
    wcnt_d   = '0;
    done     = 1'b0;
    ill_op   = 1'b0;
    mem_err  = 1'b0;
    PCout    = 1'b0;
    IncPC    = 1'b0;
    PCin     = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    ZHighout = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    Rin      = '0;
    Rout     = '0;
    alu_op   = '0;
    unique case (state)
      IDLE: begin
        if (start) state_d = T0;
      end
      T0: begin
        PCout   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        MARin   = 1'b1;
        state_d = T1;
      end
      T1: begin
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        // ready wins over timeout on the last allowed cycle
        if (mem_rdy) begin
          PCin    = 1'b1;
          state_d = T2;
        end else if (wcnt == CW'(MEM_TO - 1)) begin
          mem_err = 1'b1;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt + CW'(1);
        end
      end
      T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = T3;
      end
      T3: begin
        if (legal(op_ir)) begin
          Rout    = onehot(rb_ir);
          Yin     = 1'b1;
          state_d = T4;
        end else begin
          ill_op  = 1'b1;
          state_d = IDLE;
        end
      end
      T4: begin
        Rout    = onehot(rc_q);
        Zin     = 1'b1;
        alu_op  = op_q;
        state_d = T5;
      end
      T5: begin
        Zlowout = 1'b1;
        if (long_op) begin
          LOin    = 1'b1;
          state_d = T6;
        end else begin
          Rin     = onehot(ra_q);
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      T6: begin
        ZHighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: per-instruction expected strobe trace
// built from the T-state rules, checked every cycle on negedge.
module tb_alu_ctrl_seq;

  typedef struct packed {
    logic busy, done, ill_op, mem_err;
    logic PCout, IncPC, PCin, MARin, Read, MDRin;
    logic MDRout, IRin, Yin, Zin, Zlowout, ZHighout;
    logic LOin, HIin;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic [4:0]  alu_op;
  } out_t;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        mem_rdy = 1'b0;
  logic [31:0] ir = '0;

  logic busy, done, ill_op, mem_err;
  logic PCout, IncPC, PCin, MARin, Read, MDRin;
  logic MDRout, IRin, Yin, Zin, Zlowout, ZHighout;
  logic LOin, HIin;
  logic [15:0] Rin, Rout;
  logic [4:0]  alu_op;

  int checks = 0;
  int errors = 0;

  out_t exp_q[$];
  out_t seq[$];

  alu_ctrl_seq #(.DATA_W(32), .NREGS(16), .MEM_TO(8)) dut (
    .clock(clock), .clear(clear), .start(start),
    .mem_rdy(mem_rdy), .ir(ir),
    .busy(busy), .done(done), .ill_op(ill_op),
    .mem_err(mem_err), .PCout(PCout), .IncPC(IncPC),
    .PCin(PCin), .MARin(MARin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .ZHighout(ZHighout), .LOin(LOin), .HIin(HIin),
    .Rin(Rin), .Rout(Rout), .alu_op(alu_op)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    out_t act, e;
    act = {busy, done, ill_op, mem_err,
           PCout, IncPC, PCin, MARin, Read, MDRin,
           MDRout, IRin, Yin, Zin, Zlowout, ZHighout,
           LOin, HIin, Rin, Rout, alu_op};
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL outputs @%0t: got %h exp %h",
               $time, act, e);
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h exp %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op,
    input logic [3:0] ra, input logic [3:0] rb,
    input logic [3:0] rc);
    mk = {op, ra, rb, rc, 15'h0};
  endfunction

  // Expected per-cycle outputs, from the start cycle onward.
  task automatic build(input logic [4:0] op,
    input logic [3:0] ra, input logic [3:0] rb,
    input logic [3:0] rc, input int delay);
    out_t v;
    bit legal, long_op;
    legal = op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                       5'd8, 5'd9, 5'd10, 5'd14, 5'd15};
    long_op = (op == 5'd14) || (op == 5'd15);
    seq.delete();
    v = '0;
    seq.push_back(v);
    v.busy = 1; v.PCout = 1; v.IncPC = 1;
    v.Zin = 1; v.MARin = 1;
    seq.push_back(v);
    for (int i = 0; i < 8; i++) begin
      v = '0;
      v.busy = 1; v.Zlowout = 1; v.Read = 1; v.MDRin = 1;
      if (i == delay) v.PCin = 1;
      if (i == 7 && delay > 7) v.mem_err = 1;
      seq.push_back(v);
      if (v.mem_err) return;
      if (v.PCin) break;
    end
    v = '0;
    v.busy = 1; v.MDRout = 1; v.IRin = 1;
    seq.push_back(v);
    v = '0;
    v.busy = 1;
    if (!legal) begin
      v.ill_op = 1;
      seq.push_back(v);
      return;
    end
    v.Rout = 16'h1 << rb; v.Yin = 1;
    seq.push_back(v);
    v = '0;
    v.busy = 1; v.Rout = 16'h1 << rc; v.Zin = 1;
    v.alu_op = op;
    seq.push_back(v);
    v = '0;
    v.busy = 1; v.Zlowout = 1;
    if (long_op) v.LOin = 1;
    else begin
      v.Rin = 16'h1 << ra; v.done = 1;
    end
    seq.push_back(v);
    if (!long_op) return;
    v = '0;
    v.busy = 1; v.ZHighout = 1; v.HIin = 1; v.done = 1;
    seq.push_back(v);
  endtask

  task automatic run(input logic [31:0] irv, input int delay,
                     input bit busy_start, input int abort_at);
    int n, t3;
    build(irv[31:27], irv[26:23], irv[22:19],
          irv[18:15], delay);
    if (abort_at >= 0) begin
      while (seq.size() > abort_at + 1) void'(seq.pop_back());
      seq[abort_at] = '0;
    end
    n  = seq.size();
    t3 = delay + 4;
    @(posedge clock); #1;
    foreach (seq[k]) exp_q.push_back(seq[k]);
    for (int c = 0; c < n; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
      end
      start   = (c == 0) || busy_start;
      mem_rdy = (c >= 2) && (c - 2 >= delay);
      ir      = (c == t3) ? irv : irv ^ 32'hA5A5_5A5A;
      if (c == abort_at) begin
        #2 clear = 1'b0;
        #1;
        chk("abort busy", {31'h0, busy}, 32'h0);
        chk("abort Rout", {16'h0, Rout}, 32'h0);
        chk("abort alu_op", {27'h0, alu_op}, 32'h0);
      end
    end
    @(posedge clock); #1;
    start   = 1'b0;
    mem_rdy = 1'b0;
    if (abort_at >= 0) begin
      #3 clear = 1'b1;
      repeat (3) @(posedge clock);
    end
  endtask

  initial begin
    // model pins: or R1,R2,R3
    build(5'b01010, 4'd1, 4'd2, 4'd3, 0);
    chk("pin or len", seq.size(), 7);
    chk("pin or T3 Rout", {16'h0, seq[4].Rout}, 32'h0004);
    chk("pin or T4 Rout", {16'h0, seq[5].Rout}, 32'h0008);
    chk("pin or T4 alu", {27'h0, seq[5].alu_op}, 32'h0A);
    chk("pin or T5 Rin", {16'h0, seq[6].Rin}, 32'h0002);
    chk("pin or T5 done", {31'h0, seq[6].done}, 32'h1);
    build(5'b01110, 4'd0, 4'd4, 4'd5, 0);
    chk("pin mul len", seq.size(), 8);
    chk("pin mul T5", {seq[6].LOin, seq[6].Rin}, 32'h10000);
    chk("pin mul T6", {seq[7].ZHighout, seq[7].HIin,
                       seq[7].done}, 32'h7);
    build(5'b00011, 4'd1, 4'd1, 4'd1, 3);
    chk("pin wait PCin", {seq[2].PCin, seq[3].PCin,
                          seq[4].PCin, seq[5].PCin}, 32'h1);
    build(5'b00011, 4'd1, 4'd1, 4'd1, 8);
    chk("pin to len", seq.size(), 10);
    chk("pin to err", {31'h0, seq[9].mem_err}, 32'h1);

    repeat (2) @(posedge clock);
    #3 clear = 1'b1;

    run(mk(5'b01010, 4'd1, 4'd2, 4'd3), 0, 0, -1);
    run(mk(5'b00011, 4'd5, 4'd6, 4'd7), 3, 0, -1);
    run(mk(5'b01110, 4'd0, 4'd4, 4'd5), 0, 0, -1);
    run(mk(5'b01111, 4'd15, 4'd15, 4'd15), 1, 1, -1);
    run(mk(5'b11111, 4'd2, 4'd3, 4'd4), 0, 0, -1);
    run(mk(5'b00100, 4'd9, 4'd9, 4'd2), 8, 1, -1);
    run(mk(5'b01001, 4'd3, 4'd8, 4'd3), 7, 0, -1);
    run(mk(5'b00011, 4'd1, 4'd2, 4'd3), 0, 0, 5);
    for (int op = 0; op < 32; op++)
      run(mk(op[4:0], 4'(op), 4'(op * 3), 4'(op * 7)),
          op % 3, 0, -1);

    repeat (3) @(posedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_W 32: instruction width.
- NREGS 16: register count; REG_AW = clog2(NREGS).
- MEM_TO 8: max T1 wait cycles.
REQ-002 Ports (name, direction, width, meaning):
- clock in 1: sole clock, rising edge.
- clear in 1: asynchronous, active-low reset.
- start in 1: begin instruction.
- mem_rdy in 1: memory read data valid.
- ir in DATA_W: IR contents, valid from T3.
- busy out 1: not IDLE.
- done out 1: last T-state.
- ill_op out 1: illegal-opcode pulse.
- mem_err out 1: read-timeout pulse.
- PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout, ZHighout, LOin, HIin out 1 each: datapath strobes.
- Rin out NREGS: one-hot register load.
- Rout out NREGS: one-hot register drive.
- alu_op out 5: ALU operation select.

Function
REQ-003 Fields: opcode = ir[DATA_W-1 -: 5]; ra, rb, rc = next three REG_AW-bit fields below it, MSB first.
REQ-004 Legal opcodes: 00011 add, 00100 sub, 00101 shr, 00110 shl, 00111 ror, 01000 rol, 01001 and, 01010 or, 01110 mul, 01111 div; all others illegal.
REQ-005 States: IDLE, T0, T1, T2, T3, T4, T5, T6; binary state register.
REQ-006 Strobes are decoded from state plus captured fields (and mem_rdy in T1); every strobe not listed for a state is 0.
REQ-007 IDLE: all strobes 0; start=1 -> T0 next edge. start outside IDLE is ignored.
REQ-008 T0: PCout, IncPC, Zin, MARin -> T1.
REQ-009 T1: Zlowout, Read, MDRin held every cycle; PCin=1 only in the cycle mem_rdy=1; mem_rdy=1 -> T2.
REQ-010 T1 wait counter counts cycles in T1; at the MEM_TO-th cycle with mem_rdy=0: mem_err=1 that cycle -> IDLE.
REQ-011 T2: MDRout, IRin -> T3.
REQ-012 T3: captures opcode/ra/rb/rc from ir at exit edge; drives Rout[rb] (decoded from live ir), Yin. Illegal opcode: ill_op=1, Rout=0, Yin=0 -> IDLE.
REQ-013 T4: Rout[rc], Zin, alu_op=captured opcode -> T5.
REQ-014 T5 non-mul/div: Zlowout, Rin[ra], done -> IDLE.
REQ-015 T5 mul/div: Zlowout, LOin, Rin=0 -> T6.
REQ-016 T6: ZHighout, HIin, done -> IDLE.
REQ-017 alu_op = 0 outside T4; Rin/Rout have at most one bit set.
REQ-018 rb==rc legal; ra==rb or ra==rc legal; no hazard handling.
REQ-019 busy=1 in every state except IDLE.

Reset
REQ-020 clear=0 asynchronously forces IDLE, wait counter 0, captured fields 0, all outputs 0, from any state.
REQ-021 First rising edge after clear rises behaves as IDLE; start must be sampled high at that edge to launch.

Verification
REQ-022 clear=0 during T4 of an add -> all outputs 0 immediately, busy=0; no Rin pulse follows.
REQ-023 or R1,R2,R3 (opcode 01010, ra=1, rb=2, rc=3), mem_rdy=1 -> T0..T5 in 6 cycles; Rout=0x0004 in T3, Rout=0x0008 with alu_op=01010 in T4, Rin=0x0002 with done in T5; IDLE next.
REQ-024 mem_rdy low 3 cycles then high -> T1 lasts 4 cycles, Read/MDRin high all 4, PCin high only in 4th.
REQ-025 mul R0,R4,R5 (opcode 01110) -> T5 LOin=1, Rin=0; T6 ZHighout=HIin=done=1; 7 cycles total.
REQ-026 opcode 11111 -> ill_op=1 in T3, Rout=0, IDLE next; no Zin/Rin after T0.
REQ-027 MEM_TO=8, mem_rdy held 0 -> mem_err=1 on 8th T1 cycle, IDLE next, PCin never asserted; start during busy ignored.
